trivium_sched: RTL and testbench

Sequencing controller and two-port keystream arbiter for the Trivium cipher core. Accepts an 80-bit key and an 80-bit IV over a valid/ready handshake, loads the core and runs the 1152-round warm-up as 144 byte-steps. It then shares the core's keystream between two requesters, one byte per cycle, under round-robin arbitration. Enforces a per-key byte budget, after which a rekey is required.

---
 rtl/trivium_sched.sv | 169 ++++++++++++++++
 tb/tb_trivium_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_sched.sv
// trivium_sched: key/IV intake, Trivium warm-up sequencing and round-robin
// sharing of the keystream between two byte requesters, with a per-key
// byte budget that forces a rekey once spent.
module trivium_sched #(
  parameter int WARM_STEPS = 144,
  parameter int MAX_BYTES  = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [79:0] cfg_key,
  input  logic [79:0] cfg_iv,
  input  logic [1:0]  req_valid,
  input  logic [7:0]  req0_data,
  input  logic [7:0]  req1_data,
  output logic [1:0]  req_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [7:0]  rsp_data,
  output logic        core_load,
  output logic [79:0] core_key,
  output logic [79:0] core_iv,
  output logic        core_step,
  input  logic [7:0]  core_ks,
  output logic        busy,
  output logic        exhausted
);

  localparam int BW = $clog2(MAX_BYTES + 1);
  localparam int WW = $clog2(WARM_STEPS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARMUP,
    S_READY,
    S_EXHAUST
  } state_t;

  state_t        state_q, state_d;
  logic [79:0]   key_q, key_d;
  logic [79:0]   iv_q, iv_d;
  logic [WW-1:0] warm_cnt_q, warm_cnt_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [BW-1:0] byte_inc;
  logic          prio_q, prio_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          core_load_q, core_load_d;
  logic          cfg_ready_q, cfg_ready_d;
  logic          busy_q, busy_d;
  logic          exhausted_q, exhausted_d;
  logic          cfg_accept;
  logic          sel1;
  logic [1:0]    grant;
  logic          step;

  // Next-state, grant arbitration and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    iv_d        = iv_q;
    warm_cnt_d  = warm_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    prio_d      = prio_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    grant       = 2'b00;
    step        = 1'b0;
    cfg_accept  = cfg_valid & cfg_ready_q;
    byte_inc    = byte_cnt_q + BW'(1);
    sel1        = req_valid[1] & (~req_valid[0] | prio_q);

    case (state_q)
      S_IDLE, S_EXHAUST: begin
        if (cfg_accept) begin
          key_d   = cfg_key;
          iv_d    = cfg_iv;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        warm_cnt_d = '0;
        byte_cnt_d = '0;
        state_d    = S_WARMUP;
      end
      S_WARMUP: begin
        step       = 1'b1;
        warm_cnt_d = warm_cnt_q + WW'(1);
        if (warm_cnt_q == WW'(WARM_STEPS - 1)) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (cfg_accept) begin
          key_d   = cfg_key;
          iv_d    = cfg_iv;
          state_d = S_LOAD;
        end else if (|req_valid) begin
          grant       = sel1 ? 2'b10 : 2'b01;
          step        = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_id_d    = sel1;
          rsp_data_d  = (sel1 ? req1_data : req0_data) ^ core_ks;
          prio_d      = ~sel1;
          byte_cnt_d  = byte_inc;
          if (byte_inc == BW'(MAX_BYTES)) begin
            state_d = S_EXHAUST;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    core_load_d = (state_d == S_LOAD);
    cfg_ready_d = (state_d == S_IDLE) || (state_d == S_READY) || (state_d == S_EXHAUST);
    busy_d      = (state_d == S_LOAD) || (state_d == S_WARMUP);
    exhausted_d = (state_d == S_EXHAUST);
  end

  // State, counters, latched key/IV and registered outputs; reset drops everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      iv_q        <= '0;
      warm_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      prio_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      core_load_q <= 1'b0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      exhausted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      iv_q        <= iv_d;
      warm_cnt_q  <= warm_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      core_load_q <= core_load_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      exhausted_q <= exhausted_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign req_ready = grant;
  assign core_step = step;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign core_load = core_load_q;
  assign core_key  = key_q;
  assign core_iv   = iv_q;
  assign busy      = busy_q;
  assign exhausted = exhausted_q;

endmodule

// File: tb/tb_trivium_sched.sv
// Directed bench for trivium_sched: one instance with the full byte budget,
// a second with a budget of 4 bytes sharing the same stimulus.
module tb_trivium_sched;

  localparam logic [79:0] KEY1 = 80'h0123_4567_89AB_CDEF_0123;
  localparam logic [79:0] KEY2 = 80'hFEDC_BA98_7654_3210_FEDC;
  localparam logic [79:0] IV2  = 80'h1111_2222_3333_4444_5555;
  localparam logic [79:0] KEY3 = 80'hA5A5_5A5A_A5A5_5A5A_A5A5;
  localparam logic [79:0] IV3  = 80'h0F0F_0F0F_0F0F_0F0F_0F0F;
  localparam logic [79:0] KEY4 = 80'h7777_8888_9999_AAAA_BBBB;
  localparam logic [79:0] IV4  = 80'h1234_5678_9ABC_DEF0_1234;

  logic clk = 1'b0;
  logic rst;
  logic cfg_valid;
  logic [79:0] cfg_key, cfg_iv;
  logic [1:0] req_valid;
  logic [7:0] req0_data, req1_data, core_ks;

  logic cfg_ready, rsp_valid, rsp_id, core_load, core_step, busy, exhausted;
  logic [1:0] req_ready;
  logic [7:0] rsp_data;
  logic [79:0] core_key, core_iv;

  logic x_cfg_ready, x_rsp_valid, x_rsp_id, x_core_load, x_core_step, x_busy, x_exhausted;
  logic [1:0] x_req_ready;
  logic [7:0] x_rsp_data;
  logic [79:0] x_core_key, x_core_iv;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trivium_sched dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .req_valid(req_valid), .req0_data(req0_data), .req1_data(req1_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .core_load(core_load), .core_key(core_key), .core_iv(core_iv),
    .core_step(core_step), .core_ks(core_ks), .busy(busy), .exhausted(exhausted)
  );

  trivium_sched #(.WARM_STEPS(144), .MAX_BYTES(4)) dut_x (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(x_cfg_ready), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .req_valid(req_valid), .req0_data(req0_data), .req1_data(req1_data),
    .req_ready(x_req_ready), .rsp_valid(x_rsp_valid), .rsp_id(x_rsp_id), .rsp_data(x_rsp_data),
    .core_load(x_core_load), .core_key(x_core_key), .core_iv(x_core_iv),
    .core_step(x_core_step), .core_ks(core_ks), .busy(x_busy), .exhausted(x_exhausted)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cv, input logic [79:0] k, input logic [79:0] iv,
                               input logic [1:0] rv, input logic [7:0] d0, input logic [7:0] d1);
    cfg_valid = cv;
    cfg_key   = k;
    cfg_iv    = iv;
    req_valid = rv;
    req0_data = d0;
    req1_data = d1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_key"}, core_key, 80'(0));
    checkOutput({tag, "_iv"}, core_iv, 80'(0));
    checkOutput({tag, "_ctl"}, 80'({cfg_ready, req_ready, rsp_valid, rsp_id, rsp_data,
                                    core_load, core_step, busy, exhausted}), 80'(0));
  endtask

  // Accept key/IV in the current cycle, then verify the LOAD cycle.
  task automatic doLoad(input logic [79:0] k, input logic [79:0] iv, input logic [1:0] rv);
    applyStimulus(1'b1, k, iv, rv, 8'h3C, 8'h5A);
    @(negedge clk);
    checkOutput("accept_cfg_ready", 80'(cfg_ready), 80'(1));
    checkOutput("accept_no_grant", 80'(req_ready), 80'(0));
    checkOutput("accept_no_step", 80'(core_step), 80'(0));
    tick();
    applyStimulus(1'b0, 80'(0), 80'(0), 2'b00, 8'h3C, 8'h5A);
    @(negedge clk);
    checkOutput("load_pulse", 80'(core_load), 80'(1));
    checkOutput("load_pulse_x", 80'(x_core_load), 80'(1));
    checkOutput("load_busy", 80'(busy), 80'(1));
    checkOutput("load_key", core_key, k);
    checkOutput("load_iv", core_iv, iv);
    checkOutput("load_no_step", 80'(core_step), 80'(0));
    checkOutput("load_no_rsp", 80'(rsp_valid), 80'(0));
    checkOutput("load_cfg_ready", 80'(cfg_ready), 80'(0));
    checkOutput("load_not_exhausted_x", 80'(x_exhausted), 80'(0));
    tick();
  endtask

  // Full 144-cycle warm-up with requests pending, then the first READY cycle.
  task automatic runWarmup();
    int hi = 0;
    int loads = 0;
    int leaks = 0;
    applyStimulus(1'b0, 80'(0), 80'(0), 2'b11, 8'h3C, 8'h5A);
    for (int i = 0; i < 144; i++) begin
      @(negedge clk);
      if (core_step === 1'b1) hi++;
      if (core_load !== 1'b0) loads++;
      if (req_ready !== 2'b00 || cfg_ready !== 1'b0 || busy !== 1'b1) leaks++;
      tick();
    end
    applyStimulus(1'b0, 80'(0), 80'(0), 2'b00, 8'h3C, 8'h5A);
    @(negedge clk);
    checkOutput("warm_steps", 80'(hi), 80'(144));
    checkOutput("warm_no_reload", 80'(loads), 80'(0));
    checkOutput("warm_no_grant_no_cfg", 80'(leaks), 80'(0));
    checkOutput("ready_no_step", 80'(core_step), 80'(0));
    checkOutput("ready_cfg_ready", 80'(cfg_ready), 80'(1));
    checkOutput("ready_cfg_ready_x", 80'(x_cfg_ready), 80'(1));
    checkOutput("ready_not_busy", 80'(busy), 80'(0));
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hi;
    int steps;
    logic [1:0] exp_g;
    rst = 1'b0;
    core_ks = 8'hA5;
    applyStimulus(1'b0, 80'(0), 80'(0), 2'b00, 8'h00, 8'h00);
    #1 rst = 1'b1;
    tick();
    @(negedge clk);
    checkAllZero("reset");
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("idle_cfg_ready", 80'(cfg_ready), 80'(1));
    checkOutput("idle_not_busy", 80'(busy), 80'(0));
    checkOutput("idle_no_step", 80'(core_step), 80'(0));
    tick();

    $display("[TB] load sequence");
    doLoad(KEY1, 80'(0), 2'b00);
    runWarmup();

    $display("[TB] single requester");
    applyStimulus(1'b0, 80'(0), 80'(0), 2'b01, 8'h3C, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("single_grant", 80'(req_ready), 80'(2'b01));
      checkOutput("single_step", 80'(core_step), 80'(1));
      if (i > 0) begin
        checkOutput("single_rsp_valid", 80'(rsp_valid), 80'(1));
        checkOutput("single_rsp_data", 80'(rsp_data), 80'(8'h99));
        checkOutput("single_rsp_id", 80'(rsp_id), 80'(0));
      end
      tick();
    end
    applyStimulus(1'b0, 80'(0), 80'(0), 2'b00, 8'h3C, 8'h00);
    @(negedge clk);
    checkOutput("single_last_rsp_valid", 80'(rsp_valid), 80'(1));
    checkOutput("single_last_rsp_data", 80'(rsp_data), 80'(8'h99));
    checkOutput("idle_req_no_grant", 80'(req_ready), 80'(0));
    checkOutput("idle_req_no_step", 80'(core_step), 80'(0));
    tick();
    @(negedge clk);
    checkOutput("rsp_one_cycle", 80'(rsp_valid), 80'(0));
    tick();

    applyStimulus(1'b0, 80'(0), 80'(0), 2'b10, 8'h00, 8'h5A);
    @(negedge clk);
    checkOutput("lone1_grant", 80'(req_ready), 80'(2'b10));
    tick();
    applyStimulus(1'b0, 80'(0), 80'(0), 2'b00, 8'h00, 8'h5A);
    @(negedge clk);
    checkOutput("lone1_rsp_id", 80'(rsp_id), 80'(1));
    checkOutput("lone1_rsp_data", 80'(rsp_data), 80'(8'hFF));
    tick();

    $display("[TB] round-robin");
    steps = 0;
    applyStimulus(1'b0, 80'(0), 80'(0), 2'b11, 8'h3C, 8'h5A);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      checkOutput("rr_grant", 80'(req_ready), 80'(exp_g));
      if (core_step === 1'b1) steps++;
      if (i > 0) begin
        checkOutput("rr_rsp_valid", 80'(rsp_valid), 80'(1));
        checkOutput("rr_rsp_id", 80'(rsp_id), 80'((i - 1) % 2));
        checkOutput("rr_rsp_data", 80'(rsp_data), ((i - 1) % 2 == 0) ? 80'(8'h99) : 80'(8'hFF));
      end
      tick();
    end
    checkOutput("rr_steps", 80'(steps), 80'(6));

    $display("[TB] rekey collision");
    applyStimulus(1'b1, KEY2, IV2, 2'b11, 8'h3C, 8'h5A);
    @(negedge clk);
    checkOutput("coll_no_grant", 80'(req_ready), 80'(0));
    checkOutput("coll_no_step", 80'(core_step), 80'(0));
    checkOutput("coll_cfg_ready", 80'(cfg_ready), 80'(1));
    checkOutput("rr_last_rsp_valid", 80'(rsp_valid), 80'(1));
    checkOutput("rr_last_rsp_id", 80'(rsp_id), 80'(1));
    checkOutput("rr_last_rsp_data", 80'(rsp_data), 80'(8'hFF));
    tick();
    applyStimulus(1'b0, 80'(0), 80'(0), 2'b00, 8'h3C, 8'h5A);
    @(negedge clk);
    checkOutput("coll_load", 80'(core_load), 80'(1));
    checkOutput("coll_no_rsp", 80'(rsp_valid), 80'(0));
    checkOutput("coll_key", core_key, KEY2);
    checkOutput("coll_iv", core_iv, IV2);
    tick();
    runWarmup();

    $display("[TB] exhaustion with 4-byte budget");
    applyStimulus(1'b0, 80'(0), 80'(0), 2'b01, 8'h3C, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("exh_grant_x", 80'(x_req_ready), (i < 4) ? 80'(2'b01) : 80'(0));
      checkOutput("exh_step_x", 80'(x_core_step), (i < 4) ? 80'(1) : 80'(0));
      checkOutput("exh_flag_x", 80'(x_exhausted), (i == 4) ? 80'(1) : 80'(0));
      if (i > 0) begin
        checkOutput("exh_rsp_valid_x", 80'(x_rsp_valid), 80'(1));
        checkOutput("exh_rsp_data_x", 80'(x_rsp_data), 80'(8'h99));
      end
      tick();
    end
    applyStimulus(1'b0, 80'(0), 80'(0), 2'b00, 8'h3C, 8'h00);
    @(negedge clk);
    checkOutput("exh_rsp_done_x", 80'(x_rsp_valid), 80'(0));
    checkOutput("exh_hold_x", 80'(x_exhausted), 80'(1));
    checkOutput("exh_cfg_ready_x", 80'(x_cfg_ready), 80'(1));
    checkOutput("full_budget_not_exh", 80'(exhausted), 80'(0));
    tick();
    doLoad(KEY3, IV3, 2'b00);
    runWarmup();

    $display("[TB] reset during warm-up");
    doLoad(KEY4, IV4, 2'b00);
    hi = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (core_step === 1'b1) hi++;
      tick();
    end
    checkOutput("partial_steps", 80'(hi), 80'(70));
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkAllZero("midwarm_reset");
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("post_reset_cfg_ready", 80'(cfg_ready), 80'(1));
    checkOutput("post_reset_idle_step", 80'(core_step), 80'(0));
    checkOutput("post_reset_not_busy", 80'(busy), 80'(0));
    tick();
    doLoad(KEY1, IV3, 2'b00);
    runWarmup();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
